// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction ROM port, execute redirect and the IF/ID handshake.
// master = fetch stage, slave = surrounding core (ROM, execute, decode).
interface fetch_stage_if #(
    parameter int unsigned A_WIDTH = 32
);
    logic [A_WIDTH-1:0] imem_addr;
    logic [31:0]        imem_dout;
    logic               redirect_valid;
    logic [A_WIDTH-1:0] redirect_pc;
    logic               id_ready;
    logic               id_valid;
    logic [31:0]        id_instr;
    logic [A_WIDTH-1:0] id_pc;
    logic [A_WIDTH-1:0] id_pc_plus4;
    logic               id_fault;
    logic               halted;

    modport master (
        output imem_addr,
        input  imem_dout,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output id_fault,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  id_fault,
        input  halted
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, reads the instruction ROM and fills the IF/ID
// register with a valid/ready handshake; halts after fetching from a misaligned/unmapped PC.
module fetch_stage #(
    parameter int unsigned        A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(32'hBFC00000),
    parameter logic [A_WIDTH-1:0] ROM_BASE = A_WIDTH'(32'hBFC00000),
    parameter int unsigned        ROM_SIZE = 4096
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master fetch_io
);

    localparam logic [31:0] NopInstr = 32'h00000013;

    // One extra bit so the window bounds cannot wrap at the top of the address space.
    localparam logic [A_WIDTH:0] RomLo = {1'b0, ROM_BASE};
    localparam logic [A_WIDTH:0] RomHi = RomLo + (A_WIDTH + 1)'(ROM_SIZE) - (A_WIDTH + 1)'(4);

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic               id_valid_q, id_valid_d;
    logic [31:0]        id_instr_q, id_instr_d;
    logic [A_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [A_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic               id_fault_q, id_fault_d;

    logic [A_WIDTH:0]   pc_ext;
    logic [A_WIDTH-1:0] pc_plus4;
    logic               fault;
    logic               fire;

    assign pc_ext   = {1'b0, pc_q};
    assign pc_plus4 = pc_q + A_WIDTH'(4);
    assign fault    = (pc_q[1:0] != 2'b00) || (pc_ext < RomLo) || (pc_ext > RomHi);
    assign fire     = (state_q == StRun) && !fetch_io.redirect_valid &&
                      (!id_valid_q || fetch_io.id_ready);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_fault_d    = id_fault_q;

        if (fetch_io.redirect_valid) begin
            // Flush: any instruction still waiting for decode is dropped.
            pc_d       = fetch_io.redirect_pc;
            id_valid_d = 1'b0;
            state_d    = StRun;
        end else if (fire) begin
            id_valid_d    = 1'b1;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            if (fault) begin
                id_instr_d = NopInstr;
                id_fault_d = 1'b1;
                state_d    = StHalt;
            end else begin
                id_instr_d = fetch_io.imem_dout;
                id_fault_d = 1'b0;
                pc_d       = pc_plus4;
            end
        end else if ((state_q == StHalt) && id_valid_q && fetch_io.id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NopInstr;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_fault_q    <= id_fault_d;
        end
    end

    assign fetch_io.imem_addr   = pc_q;
    assign fetch_io.id_valid    = id_valid_q;
    assign fetch_io.id_instr    = id_instr_q;
    assign fetch_io.id_pc       = id_pc_q;
    assign fetch_io.id_pc_plus4 = id_pc_plus4_q;
    assign fetch_io.id_fault    = id_fault_q;
    assign fetch_io.halted      = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a slot-based behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] Base = 32'hBFC00000;
    localparam int unsigned Size = 4096;
    localparam logic [31:0] Nop  = 32'h00000013;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] rom [0:1023];

    fetch_stage_if #(.A_WIDTH(32)) bus ();

    fetch_stage #(
        .A_WIDTH (32),
        .RESET_PC(Base),
        .ROM_BASE(Base),
        .ROM_SIZE(Size)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fetch_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outside the window the ROM returns junk that must never reach id_instr.
    assign bus.imem_dout = fetch_ok(bus.imem_addr) ? rom[bus.imem_addr[11:2]]
                                                   : (32'hBAD0BAD0 ^ bus.imem_addr);

    function automatic bit fetch_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (longint'(a) >= longint'(Base)) &&
               (longint'(a) + 4 <= longint'(Base) + longint'(Size));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: one IF/ID slot; decode drains it, then a running fetcher refills an empty slot.
    logic [31:0] m_pc, m_instr, m_idpc, m_plus4;
    logic        m_valid, m_fault, m_halt;
    bit          m_live = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("halted", bus.halted, m_halt);
            chk("id_valid", bus.id_valid, m_valid);
            chk("id_instr", bus.id_instr, m_instr);
            chk("id_pc", bus.id_pc, m_idpc);
            chk("id_pc_plus4", bus.id_pc_plus4, m_plus4);
            chk("id_fault", bus.id_fault, m_fault);
        end
        if (rst) begin
            m_live  = 1;
            m_pc    = Base;
            m_valid = 0;
            m_instr = Nop;
            m_idpc  = 0;
            m_plus4 = 0;
            m_fault = 0;
            m_halt  = 0;
        end else if (m_live) begin
            if (bus.redirect_valid) begin
                m_pc    = bus.redirect_pc;
                m_valid = 0;
                m_halt  = 0;
            end else begin
                if (m_valid && bus.id_ready) m_valid = 0;
                if (!m_halt && !m_valid) begin
                    m_valid = 1;
                    m_idpc  = m_pc;
                    m_plus4 = m_pc + 32'd4;
                    if (fetch_ok(m_pc)) begin
                        m_instr = rom[m_pc[11:2]];
                        m_fault = 0;
                        m_pc    = m_pc + 32'd4;
                    end else begin
                        m_instr = Nop;
                        m_fault = 1;
                        m_halt  = 1;
                    end
                end
            end
        end
    end

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 5))
            0:       return Base + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            1:       return Base + Size - 4 * $urandom_range(1, 4);
            2:       return Base + $urandom_range(0, Size - 1);
            3:       return Base - 32'd4;
            4:       return 32'hFFFFFFFC;
            default: return Base;
        endcase
    endfunction

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0] = 32'h00100093;

        repeat (2) @(posedge clk);
        #1;
        chk("rst id_valid", bus.id_valid, 0);
        chk("rst id_instr", bus.id_instr, Nop);
        chk("rst id_pc", bus.id_pc, 0);
        chk("rst halted", bus.halted, 0);
        chk("rst imem_addr", bus.imem_addr, Base);
        rst = 1'b0;

        // Sequential fetch from reset
        step();
        chk("first id_valid", bus.id_valid, 1);
        chk("first id_instr", bus.id_instr, 32'h00100093);
        chk("first id_pc", bus.id_pc, 32'hBFC00000);
        chk("first id_pc_plus4", bus.id_pc_plus4, 32'hBFC00004);
        chk("first imem_addr", bus.imem_addr, 32'hBFC00004);
        step();
        chk("seq id_pc 1", bus.id_pc, 32'hBFC00004);
        step();
        chk("seq id_pc 2", bus.id_pc, 32'hBFC00008);

        // Back-pressure
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall id_pc", bus.id_pc, 32'hBFC00008);
            chk("stall imem_addr", bus.imem_addr, 32'hBFC0000C);
        end
        bus.id_ready = 1'b1;
        step();
        chk("resume id_pc", bus.id_pc, 32'hBFC0000C);
        chk("resume id_instr", bus.id_instr, rom[3]);

        // Redirect during a stall
        bus.id_ready = 1'b0;
        step();
        redirect_to(32'hBFC00100);
        chk("redir id_valid", bus.id_valid, 0);
        chk("redir imem_addr", bus.imem_addr, 32'hBFC00100);
        step();
        chk("redir id_valid 2", bus.id_valid, 1);
        chk("redir id_pc", bus.id_pc, 32'hBFC00100);

        // Run off the end of the ROM
        bus.id_ready = 1'b1;
        redirect_to(32'hBFC00FF8);
        step();
        chk("end id_pc ff8", bus.id_pc, 32'hBFC00FF8);
        step();
        chk("end id_pc ffc", bus.id_pc, 32'hBFC00FFC);
        chk("end id_fault ffc", bus.id_fault, 0);
        step();
        chk("oob id_fault", bus.id_fault, 1);
        chk("oob id_instr", bus.id_instr, Nop);
        chk("oob id_pc", bus.id_pc, 32'hBFC01000);
        chk("oob halted", bus.halted, 1);
        chk("oob imem_addr", bus.imem_addr, 32'hBFC01000);
        step();
        chk("oob drained", bus.id_valid, 0);
        step();
        chk("oob stays drained", bus.id_valid, 0);
        chk("oob addr stuck", bus.imem_addr, 32'hBFC01000);

        // Misaligned redirect from HALT, then recovery
        redirect_to(32'hBFC00002);
        chk("mis halted clr", bus.halted, 0);
        step();
        chk("mis id_fault", bus.id_fault, 1);
        chk("mis id_pc", bus.id_pc, 32'hBFC00002);
        chk("mis halted", bus.halted, 1);
        redirect_to(32'hBFC00000);
        chk("recover halted", bus.halted, 0);
        step();
        chk("recover id_instr", bus.id_instr, 32'h00100093);
        chk("recover id_fault", bus.id_fault, 0);

        // Reset beats a simultaneous redirect; reset clears a stalled slot
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hBFC00200;
        step();
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rst+redir imem_addr", bus.imem_addr, 32'hBFC00000);
        chk("rst+redir id_valid", bus.id_valid, 0);
        chk("rst+redir halted", bus.halted, 0);
        step();
        bus.id_ready = 1'b0;
        step();
        chk("pre-rst stall valid", bus.id_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid-stall rst valid", bus.id_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r                  = $urandom_range(0, 999);
            rst                = (r < 5);
            bus.redirect_valid = (r >= 5) && (r < 40);
            bus.redirect_pc    = rand_target();
            bus.id_ready       = ($urandom_range(0, 99) < 70);
            step();
        end
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
